// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter: opcode values and FSM states.
package calc_pkg;

    localparam logic [2:0] OP_ZERO       = 3'b000;
    localparam logic [2:0] OP_A          = 3'b001;
    localparam logic [2:0] OP_B          = 3'b010;
    localparam logic [2:0] OP_ADD        = 3'b011;
    localparam logic [2:0] OP_SUB        = 3'b100;
    localparam logic [2:0] OP_LAST_LEGAL = OP_SUB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } calc_state_t;

    // Opcodes above the last defined one produce a zero result and flag an error
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op > OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/calc_datapath.sv
// Combinational calculator: result = f(a, b, op), modulo 2^WIDTH.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    // Decode the opcode; carry and borrow fall off the top
    always_comb begin
        result = '0;
        err    = op_is_illegal(op);
        case (op)
            OP_A:    result = a;
            OP_B:    result = b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/calc_rr_arbiter.sv
// Two-way round-robin grant: a lone requester always wins, ties go to prio.
module calc_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    // One-hot grant; zero when nobody is requesting
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one calculator between two requesters: grant, latch operands,
// compute for one cycle, then hold the result until the owner takes it.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [5:0]           req_op,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 resp_err,
    output logic [CNT_W-1:0]     op_count
);

    calc_state_t       state_reg;
    logic              prio_reg;
    logic              owner_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [2:0]        op_reg;
    logic [1:0]        resp_valid_reg;
    logic [WIDTH-1:0]  resp_data_reg;
    logic              resp_err_reg;
    logic [CNT_W-1:0]  op_count_reg;

    logic [WIDTH-1:0]  a_sel [2];
    logic [WIDTH-1:0]  b_sel [2];
    logic [2:0]        op_sel [2];
    logic [1:0]        grant;
    logic              owner_next;
    logic [WIDTH-1:0]  calc_result;
    logic              calc_err;

    // Unpack the flat per-requester buses
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_sel[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign b_sel[gi]  = req_b[gi*WIDTH +: WIDTH];
            assign op_sel[gi] = req_op[gi*3 +: 3];
        end
    endgenerate

    calc_rr_arbiter u_arb (
        .valid (req_valid),
        .prio  (prio_reg),
        .grant (grant)
    );

    assign owner_next = grant[1];

    calc_datapath #(.WIDTH(WIDTH)) u_calc (
        .a      (a_reg),
        .b      (b_reg),
        .op     (op_reg),
        .result (calc_result),
        .err    (calc_err)
    );

    // Ready is offered only while idle; held low while reset is asserted
    assign req_ready  = (state_reg == ST_IDLE && !rst) ? grant : 2'b00;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;
    assign op_count   = op_count_reg;

    // Sequencer: IDLE (accept) -> EXEC (compute) -> RESP (wait for owner)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            prio_reg       <= 1'b0;
            owner_reg      <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            resp_valid_reg <= 2'b00;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        a_reg     <= a_sel[owner_next];
                        b_reg     <= b_sel[owner_next];
                        op_reg    <= op_sel[owner_next];
                        owner_reg <= owner_next;
                        prio_reg  <= ~owner_next;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data_reg  <= calc_result;
                    resp_err_reg   <= calc_err;
                    resp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's ready completes the response
                    if (resp_ready[owner_reg]) begin
                        resp_valid_reg <= 2'b00;
                        state_reg      <= ST_IDLE;
                        if (op_count_reg != {CNT_W{1'b1}}) begin
                            op_count_reg <= op_count_reg + CNT_W'(1);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter (CNT_W=4 so counter saturation is reachable).
module tb_calc_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [5:0]         req_op;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [WIDTH-1:0]   resp_data;
    logic               resp_err;
    logic [CNT_W-1:0]   op_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    calc_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one op with inputs already driven; called one step after a rising edge in IDLE.
    // With scramble set, the requester's inputs are trashed right after the transfer edge.
    task automatic run_op(input logic [1:0] exp_grant, input logic [7:0] exp_data,
                          input logic exp_err, input logic [CNT_W-1:0] exp_cnt,
                          input bit scramble);
        #1;
        check("idle_req_ready", req_ready, exp_grant);
        @(posedge clk); #1;
        if (scramble) begin
            req_valid = 2'b00;
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_op    = 6'($urandom);
        end
        check("exec_resp_valid", resp_valid, 2'b00);
        check("exec_req_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        check("resp_valid", resp_valid, exp_grant);
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, exp_err);
        resp_ready = exp_grant;
        @(posedge clk); #1;
        resp_ready = 2'b00;
        check("done_resp_valid", resp_valid, 2'b00);
        check("op_count", op_count, exp_cnt);
        $display("[TB] op grant=%b data=%0h err=%0b count=%0d", exp_grant, exp_data, exp_err, op_count);
    endtask

    task automatic do_op(input int req, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] exp_data,
                         input logic exp_err, input logic [CNT_W-1:0] exp_cnt);
        req_valid      = 2'b00;
        req_valid[req] = 1'b1;
        req_a[req*8 +: 8] = a;
        req_b[req*8 +: 8] = b;
        req_op[req*3 +: 3] = op;
        run_op(req == 0 ? 2'b01 : 2'b10, exp_data, exp_err, exp_cnt, 1'b1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 2'b00;

        // Reset state, with a request present to prove ready is held low
        req_valid = 2'b01;
        @(posedge clk); @(posedge clk); #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_resp_data", resp_data, 8'd0);
        check("rst_op_count", op_count, 4'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: 200 + 100 wraps to 44
        do_op(0, 8'd200, 8'd100, 3'b011, 8'd44, 1'b0, 4'd1);

        // 2: both held from reset, alternating 0,1,0,1
        apply_reset();
        req_valid = 2'b11;
        req_a  = {8'd9, 8'd5};
        req_b  = {8'd0, 8'd7};
        req_op = {3'b001, 3'b100};
        run_op(2'b01, 8'hFE, 1'b0, 4'd1, 1'b0);
        run_op(2'b10, 8'd9,  1'b0, 4'd2, 1'b0);
        run_op(2'b01, 8'hFE, 1'b0, 4'd3, 1'b0);
        run_op(2'b10, 8'd9,  1'b0, 4'd4, 1'b0);
        req_valid = 2'b00;

        // 3: illegal and remaining opcodes
        do_op(0, 8'd3, 8'd4, 3'b110, 8'd0, 1'b1, 4'd5);
        do_op(0, 8'd3, 8'd4, 3'b000, 8'd0, 1'b0, 4'd6);
        do_op(1, 8'd1, 8'h5A, 3'b010, 8'h5A, 1'b0, 4'd7);
        do_op(1, 8'd1, 8'h5A, 3'b111, 8'd0, 1'b1, 4'd8);

        // 4: owner stalls the response; non-owner ready is ignored
        req_valid = 2'b10;
        req_a[15:8] = 8'd10; req_b[15:8] = 8'd20; req_op[5:3] = 3'b011;
        #1;
        check("t4_req_ready", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_a[7:0] = 8'd1; req_b[7:0] = 8'd1; req_op[2:0] = 3'b011;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            resp_ready = (i % 2 == 0) ? 2'b01 : 2'b00;
            check("t4_hold_valid", resp_valid, 2'b10);
            check("t4_hold_data", resp_data, 8'd30);
            check("t4_hold_ready", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        check("t4_count_held", op_count, 4'd8);
        resp_ready = 2'b10;
        @(posedge clk); #1;
        resp_ready = 2'b00;
        check("t4_done_valid", resp_valid, 2'b00);
        check("t4_idle_ready", req_ready, 2'b01);
        check("t4_count", op_count, 4'd9);
        $display("[TB] op grant=10 data=1e err=0 count=%0d", op_count);
        req_valid = 2'b00;
        @(posedge clk); #1;

        // 5: reset during EXEC (requester 0 owns it, so prio would be 1)
        req_valid = 2'b01;
        req_a[7:0] = 8'd2; req_b[7:0] = 8'd3; req_op[2:0] = 3'b011;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        check("t5_req_ready", req_ready, 2'b00);
        check("t5_resp_valid", resp_valid, 2'b00);
        check("t5_resp_data", resp_data, 8'd0);
        check("t5_resp_err", resp_err, 1'b0);
        check("t5_op_count", op_count, 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t5_no_resp", resp_valid, 2'b00);
        end
        req_valid = 2'b11;
        #1;
        check("t5_prio_reset", req_ready, 2'b01);
        req_valid = 2'b00;
        @(posedge clk); #1;

        // 6: counter saturates at 4'hF
        for (int i = 1; i <= 17; i++) begin
            do_op(0, 8'(i), 8'd0, 3'b001, 8'(i), 1'b0, (i >= 15) ? 4'hF : 4'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
